// File: rtl/maq_ms.sv
// Seconds/minutes timekeeping stage: 1 Hz prescaler plus BCD mm:ss counters,
// with the carry qualifiers the hours stage consumes on the same tick.
module maq_ms #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       maqms_clock,
    input  logic       reset,
    input  logic       run,
    input  logic       set_m,
    output logic       enable_1hz,
    output logic [3:0] secs_lsd,
    output logic [2:0] secs_msd,
    output logic [3:0] mins_lsd,
    output logic [2:0] mins_msd,
    output logic       inc_m,
    output logic       inc_h
);

    localparam int            PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    // One base-60 field held as two BCD digits (tens 0-5, units 0-9).
    typedef struct packed {
        logic [2:0] msd;
        logic [3:0] lsd;
    } bcd60_t;

    function automatic logic bcd60_is_59(input bcd60_t v);
        return (v.msd == 3'd5) && (v.lsd == 4'd9);
    endfunction

    function automatic bcd60_t bcd60_inc(input bcd60_t v);
        bcd60_t res;
        res = v;
        if (v.lsd == 4'd9) begin
            res.lsd = 4'd0;
            res.msd = (v.msd == 3'd5) ? 3'd0 : v.msd + 3'd1;
        end else begin
            res.lsd = v.lsd + 4'd1;
        end
        return res;
    endfunction

    logic [PW-1:0] r_presc;
    bcd60_t        r_secs;
    bcd60_t        r_mins;

    logic [PW-1:0] w_presc_nxt;
    bcd60_t        w_secs_nxt;
    bcd60_t        w_mins_nxt;
    logic          w_tick;
    logic          w_secs_59;
    logic          w_mins_59;

    // The carries are unregistered so they line up with the tick at zero latency.
    assign w_tick    = run && !set_m && (r_presc == PRESC_LAST);
    assign w_secs_59 = bcd60_is_59(r_secs);
    assign w_mins_59 = bcd60_is_59(r_mins);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // branches below leaves one unassigned, which would infer a latch.
        w_presc_nxt = r_presc;
        w_secs_nxt  = r_secs;
        w_mins_nxt  = r_mins;

        if (set_m) begin
            // Time-setting step: no hour carry, restart the second from zero.
            w_presc_nxt = '0;
            w_secs_nxt  = '0;
            w_mins_nxt  = bcd60_inc(r_mins);
        end else if (run) begin
            w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_ONE;
            if (w_tick) begin
                w_secs_nxt = bcd60_inc(r_secs);
                if (w_secs_59) begin
                    w_mins_nxt = bcd60_inc(r_mins);
                end
            end
        end
    end

    always_ff @(posedge maqms_clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_secs  <= '0;
            r_mins  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state, independent of statement order.
            r_presc <= w_presc_nxt;
            r_secs  <= w_secs_nxt;
            r_mins  <= w_mins_nxt;
        end
    end

    always_ff @(posedge maqms_clock) begin
        if (!reset) begin
            assert (r_secs.lsd <= 4'd9 && r_secs.msd <= 3'd5 &&
                    r_mins.lsd <= 4'd9 && r_mins.msd <= 3'd5);
        end
    end

    assign enable_1hz = w_tick;
    assign secs_lsd   = r_secs.lsd;
    assign secs_msd   = r_secs.msd;
    assign mins_lsd   = r_mins.lsd;
    assign mins_msd   = r_mins.msd;
    assign inc_m      = w_secs_59;
    assign inc_h      = w_mins_59;

endmodule

// File: tb/tb_maq_ms.sv
// Self-checking bench for maq_ms: vector table, corner-case sequences and a
// randomized run checked against a seconds-of-hour reference model.
module tb_maq_ms;

    localparam int CLK_HZ = 4;

    logic       clk;
    logic       rst;
    logic       run;
    logic       set_m;
    logic       en;
    logic [3:0] s_lsd;
    logic [2:0] s_msd;
    logic [3:0] m_lsd;
    logic [2:0] m_msd;
    logic       inc_m;
    logic       inc_h;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: prescaler count, seconds and minutes as integers.
    int m_presc;
    int m_sec;
    int m_min;

    typedef struct {
        logic run;
        logic set;
        logic en;
        int   sec;
        int   min;
    } vec_t;

    vec_t tbl [17];

    maq_ms #(.CLK_HZ(CLK_HZ)) dut (
        .maqms_clock (clk),
        .reset       (rst),
        .run         (run),
        .set_m       (set_m),
        .enable_1hz  (en),
        .secs_lsd    (s_lsd),
        .secs_msd    (s_msd),
        .mins_lsd    (m_lsd),
        .mins_msd    (m_msd),
        .inc_m       (inc_m),
        .inc_h       (inc_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_sec();
        return int'(s_msd) * 10 + int'(s_lsd);
    endfunction

    function automatic int cur_min();
        return int'(m_msd) * 10 + int'(m_lsd);
    endfunction

    task automatic model_reset();
        m_presc = 0;
        m_sec   = 0;
        m_min   = 0;
    endtask

    task automatic model_step(input logic r, input logic s);
        int total;
        if (s) begin
            m_min   = (m_min + 1) % 60;
            m_sec   = 0;
            m_presc = 0;
        end else if (r) begin
            if (m_presc == CLK_HZ - 1) begin
                m_presc = 0;
                total   = (m_min * 60 + m_sec + 1) % 3600;
                m_min   = total / 60;
                m_sec   = total % 60;
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic compare_model(input logic r, input logic s);
        check("model en",    en,    (r && !s && m_presc == CLK_HZ - 1));
        check("model s_lsd", s_lsd, m_sec % 10);
        check("model s_msd", s_msd, m_sec / 10);
        check("model m_lsd", m_lsd, m_min % 10);
        check("model m_msd", m_msd, m_min / 10);
        check("model inc_m", inc_m, (m_sec == 59));
        check("model inc_h", inc_h, (m_min == 59));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " en"},    en,    0);
        check({tag, " s_lsd"}, s_lsd, 0);
        check({tag, " s_msd"}, s_msd, 0);
        check({tag, " m_lsd"}, m_lsd, 0);
        check({tag, " m_msd"}, m_msd, 0);
        check({tag, " inc_m"}, inc_m, 0);
        check({tag, " inc_h"}, inc_h, 0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
    task automatic apply(input logic r, input logic s);
        run   = r;
        set_m = s;
        #2;
    endtask

    task automatic finish_cycle(input logic r, input logic s);
        compare_model(r, s);
        model_step(r, s);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic s);
        apply(r, s);
        finish_cycle(r, s);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        run   = 1'b0;
        set_m = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset held");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        set_m = 1'b0;
        model_reset();

        //           run   set   en    sec min
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 0, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 0, 2};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 0, 2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 0, 2};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 0, 2};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1, 2};

        // Vector table: first tick, pause at prescaler 2, set_m with and without run.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].run, tbl[i].set);
            check($sformatf("tbl[%0d] en", i),  en,        tbl[i].en);
            check($sformatf("tbl[%0d] sec", i), cur_sec(), tbl[i].sec);
            check($sformatf("tbl[%0d] min", i), cur_min(), tbl[i].min);
            finish_cycle(tbl[i].run, tbl[i].set);
        end

        // Pause for 10 cycles holding the prescaler at 2; tick follows one cycle after resume.
        do_reset();
        repeat (2) step(1'b1, 1'b0);
        repeat (10) begin
            apply(1'b0, 1'b0);
            check("pause en", en, 0);
            finish_cycle(1'b0, 1'b0);
        end
        apply(1'b1, 1'b0);
        check("resume en low", en, 0);
        finish_cycle(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("resume tick", en, 1);
        finish_cycle(1'b1, 1'b0);

        // 59 ticks from 00:00, then the seconds wrap into minutes.
        do_reset();
        repeat (59 * CLK_HZ) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("59s sec",   cur_sec(), 59);
        check("59s min",   cur_min(), 0);
        check("59s inc_m", inc_m,     1);
        finish_cycle(1'b1, 1'b0);
        repeat (CLK_HZ - 1) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("wrap sec",   cur_sec(), 0);
        check("wrap min",   cur_min(), 1);
        check("wrap inc_m", inc_m,     0);
        finish_cycle(1'b1, 1'b0);

        // Minutes preloaded to 59, run to 59:59: tick and both carries coincide.
        do_reset();
        repeat (59) step(1'b0, 1'b1);
        repeat (59 * CLK_HZ + CLK_HZ - 1) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("5959 en",    en,    1);
        check("5959 inc_m", inc_m, 1);
        check("5959 inc_h", inc_h, 1);
        finish_cycle(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("0000 sec",   cur_sec(), 0);
        check("0000 min",   cur_min(), 0);
        check("0000 inc_m", inc_m,     0);
        check("0000 inc_h", inc_h,     0);
        check("0000 en",    en,        0);
        finish_cycle(1'b1, 1'b0);

        // set_m on the tick cycle at 12:59.
        do_reset();
        repeat (12) step(1'b0, 1'b1);
        repeat (59 * CLK_HZ + CLK_HZ - 1) step(1'b1, 1'b0);
        apply(1'b1, 1'b1);
        check("set@tick sec", cur_sec(), 59);
        check("set@tick min", cur_min(), 12);
        check("set@tick en",  en,        0);
        finish_cycle(1'b1, 1'b1);
        apply(1'b1, 1'b0);
        check("after set sec", cur_sec(), 0);
        check("after set min", cur_min(), 13);
        check("after set en",  en,        0);
        finish_cycle(1'b1, 1'b0);
        repeat (CLK_HZ - 2) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("tick after set", en, 1);
        finish_cycle(1'b1, 1'b0);

        // Asynchronous reset between edges at 37:42.
        do_reset();
        repeat (37) step(1'b0, 1'b1);
        repeat (42 * CLK_HZ) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("pre-reset sec", cur_sec(), 42);
        check("pre-reset min", cur_min(), 37);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async reset");
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("reset hold");
        end
        rst = 1'b0;
        repeat (CLK_HZ - 1) step(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        check("first tick after reset", en, 1);
        finish_cycle(1'b1, 1'b0);

        // Randomized run/set_m traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic s;
            r = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 29) == 0);
            step(r, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/maq_ms.md
Name: maq_ms

Overview:
- Seconds/minutes timekeeping stage of the clock datapath, directly upstream of the hours counter.
- Divides the system clock down to a single-cycle 1 Hz enable and runs BCD seconds (00-59) and minutes (00-59) counters.
- Produces the carry qualifiers consumed by the hours stage: inc_m (seconds at 59) and inc_h (minutes at 59).
- Also drives the seconds/minutes digits to the display path.
- Supports pause (run) and a minute-set pulse for time adjustment.

Parameters:
- CLK_HZ, 50000000, system clock cycles per 1 Hz tick. Legal values are >= 2. Benches use 4.

Ports:
- maqms_clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = timekeeping advances; 0 = prescaler and counters hold.
- set_m  in  1  single-cycle synchronous pulse; advances minutes by one for time setting.
- enable_1hz  out  1  one-cycle tick; it is the qualifier for every counter step here and in the hours stage.
- secs_lsd  out  4  seconds units, BCD 0-9.
- secs_msd  out  3  seconds tens, 0-5.
- mins_lsd  out  4  minutes units, BCD 0-9.
- mins_msd  out  3  minutes tens, 0-5.
- inc_m  out  1  high while seconds == 59.
- inc_h  out  1  high while minutes == 59.

Behaviour:
- Reset (asynchronous, active-high):
  - Prescaler = 0.
  - All digit registers = 0.
  - enable_1hz = 0, inc_m = 0, inc_h = 0.
  - Reset asserted mid-count clears everything immediately, without waiting for a clock edge.
  - After release, the first tick comes CLK_HZ run-cycles later.
- Prescaler:
  - Width is $clog2(CLK_HZ).
  - Counts 0..CLK_HZ-1 while run=1 and set_m=0.
  - Wraps to 0 on the edge where it equals CLK_HZ-1.
  - While run=0 it holds its value; it is not cleared.
- enable_1hz:
  - Combinational: run && !set_m && (prescaler == CLK_HZ-1).
  - Exactly one cycle wide.
  - Period is CLK_HZ cycles under continuous run.
- Counting on an edge where enable_1hz = 1:
  - secs_lsd increments; it wraps 9 -> 0 and increments secs_msd.
  - secs_msd wraps 5 -> 0 when seconds == 59.
  - At seconds == 59, minutes step in the same way: mins_lsd wraps 9 -> 0 and carries into mins_msd; 59 wraps to 00.
  - At 59:59, seconds and minutes both become 00:00 on that edge.
- inc_m and inc_h:
  - Both are combinational from the current registered state. They are not gated by run or by the tick.
  - The hours stage advances when enable_1hz && inc_h && inc_m, on the same edge where minutes wrap 59 -> 00.
  - Zero-latency alignment between the tick and the carries is mandatory.
- set_m = 1 (takes priority over tick and run):
  - Minutes increment modulo 60 with no hour carry.
  - Seconds clear to 00.
  - Prescaler clears to 0.
  - enable_1hz is forced low that cycle, so the hours stage cannot step.
  - set_m at minutes 59 gives 00, and the hours are untouched.
  - set_m works even while run=0.
- run = 0: all digits hold and enable_1hz stays low.
- Digit registers never hold illegal BCD values. No states outside 00-59 are reachable.

Test Plan:
- Reset release with run=1, CLK_HZ=4 -> enable_1hz is first high in cycle 3 (counting from 0); seconds go 00 -> 01 on that edge; the pulse then repeats every 4 cycles and is one cycle wide.
- Run 59 ticks from 00:00 -> seconds=59 and inc_m=1. The next tick gives seconds=00, minutes=01 and inc_m=0.
- Preload via set_m to minutes 59, then run to seconds 59 -> inc_h=1, inc_m=1 and enable_1hz coincide for exactly one cycle. The next edge gives 00:00, with both carries low.
- Drop run to 0 mid-count (prescaler=2) for 10 cycles -> digits and prescaler frozen, enable_1hz=0. After run returns to 1, the tick occurs after 1 more cycle.
- Assert set_m in the same cycle as a tick at 12:59 -> result 13:00, enable_1hz low that cycle, prescaler reset to 0. Next tick after 4 cycles.
- Assert reset asynchronously between edges at 37:42 -> all outputs are 0 before the next clock edge and stay 0 while reset is held.
